trace_buffer: RTL and testbench
===============================

TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the PC and of each probe channel.
REQ-002 SHALL have parameter NUM_CH, default 4, number of probe channels captured alongside the PC.
REQ-003 SHALL have parameter DEPTH, default 64, record capacity; must be a power of two, at least 2.
REQ-004 SHALL have parameter CNT_W, default 16, width of the cycle stamp and window counters.
REQ-005 SHALL have ports:
- clk_in  input  1  single clock; all state on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  level; 1 arms or keeps capture, 0 forces IDLE.
- mode  input  2  0 window, 1 trigger, 2 continuous, 3 reserved and treated as 0.
- win_start  input  CNT_W  window mode: cycle stamp of the first record.
- win_len  input  CNT_W  window and trigger modes: number of records to take.
- trig_pc  input  DATA_W  trigger mode: PC value that starts capture.
- pc  input  DATA_W  probed program counter.
- ch_data  input  NUM_CH*DATA_W  probed channels; channel k occupies bits [k*DATA_W +: DATA_W].
- rd_ready  input  1  consumer accepts the head record.
- rd_valid  output  1  head record present.
- rd_data  output  (NUM_CH+1)*DATA_W  head record: {ch_data, pc}.
- rd_stamp  output  CNT_W  cycle stamp of the head record.
- count  output  log2(DEPTH)+1  records held.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky; a record was lost.
- state  output  2  current FSM state.

Function
REQ-006 SHALL implement FSM IDLE(0), ARMED(1), CAPTURE(2), DONE(3).
REQ-007 SHALL move IDLE->ARMED on the first cycle enable=1, clearing the cycle counter, capture counter and overflow flag; buffer contents SHALL NOT be cleared.
REQ-008 SHALL advance the cycle counter by 1 each cycle outside IDLE and saturate it at 2^CNT_W-1.
REQ-009 SHALL leave ARMED as follows:
- window mode: enter CAPTURE when cycle counter == win_start.
- trigger mode: enter CAPTURE when pc == trig_pc.
- continuous mode: enter CAPTURE immediately.
REQ-010 SHALL record the cycle on which the start condition is met, with stamp equal to the cycle counter on that cycle.
REQ-011 SHALL, if win_len == 0 in window or trigger mode, go directly to DONE with no record written.
REQ-012 SHALL write one record per cycle in CAPTURE and go to DONE after win_len records have been attempted (window and trigger modes).
REQ-013 SHALL stay in CAPTURE indefinitely in continuous mode.
REQ-014 SHALL return from any state to IDLE on the cycle after enable=0; DONE SHALL hold until then.
REQ-015 SHALL make a written record visible on rd_valid, rd_data and rd_stamp on the cycle after the write edge.
REQ-016 SHALL present the head record combinationally from the read pointer (first-word fall-through).
REQ-017 SHALL pop the head record on any edge where rd_valid and rd_ready are both 1; popping SHALL be allowed in every state.
REQ-018 SHALL handle a write while full as follows:
- window and trigger modes: drop the new record, set overflow, and still count the attempt.
- continuous mode: discard the oldest record, store the new one, set overflow.
REQ-019 SHALL accept both operations when a push and a pop coincide while full, with count unchanged and overflow not set.
REQ-020 SHALL wrap the read and write pointers modulo DEPTH; count SHALL never exceed DEPTH.

Reset
REQ-021 SHALL, on reset low, immediately set state=IDLE, set count, the pointers, the counters and overflow to 0, and drive rd_valid=0 and full=0.
REQ-022 SHALL discard all buffered records on reset, including a reset asserted during CAPTURE; memory contents need not be cleared.

Structure
REQ-023 SHALL take the state and mode encodings from shared package trace_pkg.
REQ-024 SHALL place storage in one sub-module, trace_fifo (parameters DEPTH and record width; ports for push, pop, overwrite-on-full, and head/count/full outputs).

Verification
REQ-025 Window mode with win_start=5 and win_len=3 -> records stamped 5, 6 and 7, then state=DONE and count=3.
REQ-026 Trigger mode with trig_pc=0x00400010 reached at cycle 9 and win_len=2 -> first record has pc=0x00400010 and stamp=9; count=2.
REQ-027 DEPTH=4, window mode with win_len=6 and rd_ready=0 -> count=4, full=1, overflow=1, and the held stamps are the first four.
REQ-028 DEPTH=4, continuous mode for 6 cycles with rd_ready=0 -> the held records are the last four written, and overflow=1.
REQ-029 Full buffer with rd_ready=1 during continuous capture -> count stays 4, overflow stays 0, and stamps pop in order.
REQ-030 Reset asserted in the middle of CAPTURE with count=2 -> state=IDLE, count=0 and rd_valid=0 immediately; after release with enable=1 the block re-enters ARMED.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared encodings for the trace buffer: FSM states, capture modes and the
// mode normalisation used wherever the mode input is interpreted.
package trace_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [1:0] MODE_WINDOW   = 2'd0;
    localparam logic [1:0] MODE_TRIGGER  = 2'd1;
    localparam logic [1:0] MODE_CONT     = 2'd2;
    localparam logic [1:0] MODE_RESERVED = 2'd3;

    // The reserved encoding behaves exactly like window mode.
    function automatic logic [1:0] eff_mode(input logic [1:0] m);
        return (m == MODE_RESERVED) ? MODE_WINDOW : m;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Record storage for the trace buffer: first-word fall-through FIFO with an
// optional overwrite-oldest behaviour when a push arrives while full.
module trace_fifo #(
    parameter int DEPTH = 64,
    parameter int REC_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     overwrite,
    input  logic [REC_W-1:0]         push_data,
    output logic [REC_W-1:0]         head_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [REC_W-1:0] mem_q [DEPTH];
    logic             pop_ok, push_ok, evict;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == FULL_CNT);
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok || overwrite);
        // Overwrite while full: the oldest record is discarded to make room.
        evict    = push_ok && full && !pop_ok;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop_ok || evict) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (push_ok && !evict && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by count_q, so stale words are never visible.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/trace_buffer.sv
// Program-counter trace capture: an arm/capture/done controller stamping
// {ch_data, pc} records into a FIFO in window, trigger or continuous mode.
module trace_buffer
    import trace_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 64,
    parameter int CNT_W  = 16
) (
    input  logic                         clk_in,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [1:0]                   mode,
    input  logic [CNT_W-1:0]             win_start,
    input  logic [CNT_W-1:0]             win_len,
    input  logic [DATA_W-1:0]            trig_pc,
    input  logic [DATA_W-1:0]            pc,
    input  logic [NUM_CH*DATA_W-1:0]     ch_data,
    input  logic                         rd_ready,
    output logic                         rd_valid,
    output logic [(NUM_CH+1)*DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]             rd_stamp,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         overflow,
    output logic [1:0]                   state
);

    localparam int REC_W  = (NUM_CH + 1) * DATA_W;
    localparam int FIFO_W = REC_W + CNT_W;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [CNT_W-1:0]  cap_q, cap_d;
    logic              ovf_q, ovf_d;
    logic [1:0]        mode_eff;
    logic              bounded, start_hit, last_rec;
    logic              push, pop;
    logic              fifo_empty, fifo_full;
    logic [FIFO_W-1:0] fifo_head;

    always_comb begin
        mode_eff = eff_mode(mode);
        bounded  = (mode_eff != MODE_CONT);
        pop      = rd_ready && !fifo_empty;
        // True when the record being attempted now is the last of win_len.
        last_rec = ({1'b0, cap_q} + (CNT_W+1)'(1)) >= {1'b0, win_len};
        case (mode_eff)
            MODE_TRIGGER: start_hit = (pc == trig_pc);
            MODE_CONT:    start_hit = 1'b1;
            default:      start_hit = (cyc_q == win_start);
        endcase

        state_d = state_q;
        cyc_d   = cyc_q;
        cap_d   = cap_q;
        ovf_d   = ovf_q;
        push    = 1'b0;

        if (state_q != ST_IDLE && cyc_q != '1) begin
            cyc_d = cyc_q + CNT_W'(1);
        end

        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARMED;
                    cyc_d   = '0;
                    cap_d   = '0;
                    ovf_d   = 1'b0;
                end
                ST_ARMED: begin
                    if (start_hit) begin
                        if (bounded && win_len == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            push    = 1'b1;
                            state_d = (bounded && last_rec) ? ST_DONE : ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    push = 1'b1;
                    if (bounded && last_rec) begin
                        state_d = ST_DONE;
                    end
                end
                default: ;
            endcase
        end

        // A dropped or overwritten record still counts as an attempt.
        if (push) begin
            if (cap_q != '1) begin
                cap_d = cap_q + CNT_W'(1);
            end
            if (fifo_full && !pop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            cap_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            cap_q   <= cap_d;
            ovf_q   <= ovf_d;
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .REC_W (FIFO_W)
    ) u_fifo (
        .clk       (clk_in),
        .rst_n     (reset),
        .push      (push),
        .pop       (pop),
        .overwrite (mode_eff == MODE_CONT),
        .push_data ({cyc_q, ch_data, pc}),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (count)
    );

    assign rd_valid = !fifo_empty;
    assign rd_data  = fifo_head[REC_W-1:0];
    assign rd_stamp = fifo_head[REC_W +: CNT_W];
    assign full     = fifo_full;
    assign overflow = ovf_q;
    assign state    = state_q;

endmodule

// File: tb/tb_trace_buffer.sv
// Randomised bench for trace_buffer: the expected record stream is derived from
// the capture rules (which cycles are recorded) feeding a bounded queue model.
`timescale 1ns/1ps
module tb_trace_buffer;

    localparam int DATA_W = 32;
    localparam int NUM_CH = 2;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 16;
    localparam int REC_W  = (NUM_CH + 1) * DATA_W;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic                     clk_in    = 1'b0;
    logic                     reset     = 1'b0;
    logic                     enable    = 1'b0;
    logic [1:0]               mode      = '0;
    logic [CNT_W-1:0]         win_start = '0;
    logic [CNT_W-1:0]         win_len   = '0;
    logic [DATA_W-1:0]        trig_pc   = '0;
    logic [DATA_W-1:0]        pc        = '0;
    logic [NUM_CH*DATA_W-1:0] ch_data   = '0;
    logic                     rd_ready  = 1'b0;
    logic                     rd_valid;
    logic [REC_W-1:0]         rd_data;
    logic [CNT_W-1:0]         rd_stamp;
    logic [CW-1:0]            count;
    logic                     full;
    logic                     overflow;
    logic [1:0]               state;

    typedef struct {
        logic [CNT_W-1:0] stamp;
        logic [REC_W-1:0] data;
    } rec_t;

    rec_t mq[$];
    logic m_ovf = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk_in = ~clk_in;

    trace_buffer #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .enable    (enable),
        .mode      (mode),
        .win_start (win_start),
        .win_len   (win_len),
        .trig_pc   (trig_pc),
        .pc        (pc),
        .ch_data   (ch_data),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_stamp  (rd_stamp),
        .count     (count),
        .full      (full),
        .overflow  (overflow),
        .state     (state)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Compare the visible FIFO side of the DUT against the queue model.
    task automatic observe(input string tag);
        n_checks++;
        if (count !== CW'(mq.size())) begin
            n_fail++;
            $display("FAIL %s count: got %0d expected %0d", tag, count, mq.size());
        end
        n_checks++;
        if (full !== (mq.size() == DEPTH)) begin
            n_fail++;
            $display("FAIL %s full: got %b expected %b", tag, full, mq.size() == DEPTH);
        end
        n_checks++;
        if (rd_valid !== (mq.size() != 0)) begin
            n_fail++;
            $display("FAIL %s rd_valid: got %b expected %b", tag, rd_valid, mq.size() != 0);
        end
        if (mq.size() != 0) begin
            n_checks++;
            if (rd_stamp !== mq[0].stamp || rd_data !== mq[0].data) begin
                n_fail++;
                $display("FAIL %s head: got stamp %0d data %h expected stamp %0d data %h",
                         tag, rd_stamp, rd_data, mq[0].stamp, mq[0].data);
            end
        end
    endtask

    task automatic model_edge(input logic rdy, input logic wr, input rec_t r, input logic cont);
        if (rdy && mq.size() > 0) mq.delete(0);
        if (wr) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(r);
            end else begin
                m_ovf = 1'b1;
                if (cont) begin
                    mq.delete(0);
                    mq.push_back(r);
                end
            end
        end
    endtask

    task automatic check_state(input string tag, input logic [1:0] exp);
        n_checks++;
        if (state !== exp) begin
            n_fail++;
            $display("FAIL %s state: got %0d expected %0d", tag, state, exp);
        end
    endtask

    task automatic check_ovf(input string tag, input logic exp);
        n_checks++;
        if (overflow !== exp) begin
            n_fail++;
            $display("FAIL %s overflow: got %b expected %b", tag, overflow, exp);
        end
    endtask

    task automatic start_run(input string tag, input logic [1:0] m, input int ws, input int wl,
                             input logic [DATA_W-1:0] tp);
        mode      = m;
        win_start = CNT_W'(ws);
        win_len   = CNT_W'(wl);
        trig_pc   = tp;
        rd_ready  = 1'b0;
        enable    = 1'b1;
        tick();
        m_ovf = 1'b0;
        check_state({tag, "_arm"}, 2'd1);
        check_ovf({tag, "_arm"}, 1'b0);
    endtask

    // Cycle c is the c-th cycle after arming; its cycle stamp is c.
    task automatic run_cycles(input string tag, input logic [1:0] m, input int ws, input int wl,
                              input int trig_cycle, input int n, input int ready_from,
                              input int ready_pct);
        logic [1:0] em;
        logic       cont;
        int         start;
        int         exp_state;
        em   = (m == 2'd3) ? 2'd0 : m;
        cont = (em == 2'd2);
        if (em == 2'd2)      start = 0;
        else if (em == 2'd1) start = trig_cycle;
        else                 start = ws;
        for (int c = 0; c < n; c++) begin
            rec_t r;
            logic wr;
            logic rdy;
            pc = $urandom;
            if (em == 2'd1) begin
                if (c == trig_cycle)  pc = trig_pc;
                else if (pc == trig_pc) pc = ~trig_pc;
            end
            for (int k = 0; k < NUM_CH; k++) ch_data[k*DATA_W +: DATA_W] = $urandom;
            rdy = (c >= ready_from) && ($urandom_range(99) < ready_pct);
            rd_ready = rdy;
            observe(tag);
            wr = (start >= 0) && (c >= start) && (cont || c < start + wl);
            r.stamp = CNT_W'(c);
            r.data  = {ch_data, pc};
            model_edge(rdy, wr, r, cont);
            tick();
        end
        rd_ready = 1'b0;
        observe({tag, "_end"});
        if (start < 0 || start >= n)                  exp_state = 1;
        else if (cont)                                exp_state = 2;
        else if (start + ((wl == 0) ? 1 : wl) <= n)   exp_state = 3;
        else                                          exp_state = 2;
        check_state({tag, "_end"}, 2'(exp_state));
        check_ovf({tag, "_end"}, m_ovf);
    endtask

    // Disable, then drain every held record in order from IDLE.
    task automatic finish_run(input string tag);
        enable   = 1'b0;
        rd_ready = 1'b0;
        tick();
        check_state({tag, "_off"}, 2'd0);
        check_ovf({tag, "_off"}, m_ovf);
        rd_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1 && mq.size() > 0; i++) begin
            observe({tag, "_drain"});
            mq.delete(0);
            tick();
        end
        rd_ready = 1'b0;
        observe({tag, "_empty"});
    endtask

    task automatic test_reset();
        #2;
        check_state("reset", 2'd0);
        observe("reset");
        check_ovf("reset", 1'b0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check_state("reset_release", 2'd0);
        observe("reset_release");
    endtask

    task automatic test_window();
        start_run("window", 2'd0, 5, 3, '0);
        run_cycles("window", 2'd0, 5, 3, -1, 12, 0, 0);
        n_checks++;
        if (count !== CW'(3) || state !== 2'd3 || rd_stamp !== 16'd5) begin
            n_fail++;
            $display("FAIL window_summary: got count %0d state %0d stamp %0d expected 3 3 5",
                     count, state, rd_stamp);
        end
        finish_run("window");
    endtask

    task automatic test_trigger();
        start_run("trigger", 2'd1, 0, 2, 32'h0040_0010);
        run_cycles("trigger", 2'd1, 0, 2, 9, 14, 0, 0);
        n_checks++;
        if (rd_data[DATA_W-1:0] !== 32'h0040_0010 || rd_stamp !== 16'd9 || count !== CW'(2)) begin
            n_fail++;
            $display("FAIL trigger_first: got pc %h stamp %0d count %0d expected 00400010 9 2",
                     rd_data[DATA_W-1:0], rd_stamp, count);
        end
        finish_run("trigger");
    endtask

    task automatic test_window_overflow();
        start_run("win_ovf", 2'd0, 2, 6, '0);
        run_cycles("win_ovf", 2'd0, 2, 6, -1, 10, 0, 0);
        n_checks++;
        if (count !== CW'(4) || full !== 1'b1 || overflow !== 1'b1 || rd_stamp !== 16'd2) begin
            n_fail++;
            $display("FAIL win_ovf_summary: got count %0d full %b ovf %b stamp %0d expected 4 1 1 2",
                     count, full, overflow, rd_stamp);
        end
        finish_run("win_ovf");
    endtask

    task automatic test_continuous_overflow();
        start_run("cont_ovf", 2'd2, 0, 0, '0);
        run_cycles("cont_ovf", 2'd2, 0, 0, -1, 6, 0, 0);
        n_checks++;
        if (overflow !== 1'b1 || rd_stamp !== 16'd2) begin
            n_fail++;
            $display("FAIL cont_ovf_summary: got ovf %b oldest stamp %0d expected 1 2", overflow, rd_stamp);
        end
        finish_run("cont_ovf");
    endtask

    task automatic test_back_to_back_full_pop();
        start_run("full_pop", 2'd2, 0, 0, '0);
        run_cycles("full_pop", 2'd2, 0, 0, -1, 10, 4, 100);
        n_checks++;
        if (count !== CW'(4) || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pop_summary: got count %0d ovf %b expected 4 0", count, overflow);
        end
        finish_run("full_pop");
    endtask

    task automatic test_zero_len_and_no_start();
        start_run("win_len0", 2'd0, 3, 0, '0);
        run_cycles("win_len0", 2'd0, 3, 0, -1, 6, 0, 0);
        finish_run("win_len0");
        start_run("trig_len0", 2'd1, 0, 0, 32'h1234_5678);
        run_cycles("trig_len0", 2'd1, 0, 0, 2, 5, 0, 0);
        finish_run("trig_len0");
        start_run("trig_miss", 2'd1, 0, 3, 32'hdead_beef);
        run_cycles("trig_miss", 2'd1, 0, 3, -1, 8, 0, 0);
        finish_run("trig_miss");
        start_run("mode3", 2'd3, 4, 2, '0);
        run_cycles("mode3", 2'd3, 4, 2, -1, 9, 0, 0);
        finish_run("mode3");
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            logic [1:0] m;
            int ws, wl, tc, n, rf, pct;
            m  = 2'($urandom_range(3));
            ws = $urandom_range(8);
            wl = $urandom_range(6);
            tc = $urandom_range(8);
            n  = $urandom_range(16, 4);
            rf = $urandom_range(n);
            case ($urandom_range(2))
                0:       pct = 0;
                1:       pct = 50;
                default: pct = 100;
            endcase
            start_run("random", m, ws, wl, $urandom);
            run_cycles("random", m, ws, wl, tc, n, rf, pct);
            finish_run("random");
        end
    endtask

    task automatic test_reset_mid_capture();
        start_run("rst_mid", 2'd2, 0, 0, '0);
        run_cycles("rst_mid", 2'd2, 0, 0, -1, 2, 0, 0);
        n_checks++;
        if (count !== CW'(2) || state !== 2'd2) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got count %0d state %0d expected 2 2", count, state);
        end
        #2;
        reset = 1'b0;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        check_state("rst_mid_async", 2'd0);
        observe("rst_mid_async");
        check_ovf("rst_mid_async", 1'b0);
        #2;
        reset = 1'b1;
        tick();
        check_state("rst_mid_rearm", 2'd1);
        observe("rst_mid_rearm");
        finish_run("rst_mid");
    endtask

    initial begin
        test_reset();
        test_window();
        test_trigger();
        test_window_overflow();
        test_continuous_overflow();
        test_back_to_back_full_pop();
        test_zero_len_and_no_start();
        test_random();
        test_reset_mid_capture();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
